// File: rtl/player_draw_fsm_if.sv
// player_draw_fsm_if: frame control, key inputs and draw/move outputs of the player draw sequencer
interface player_draw_fsm_if;
  logic       frame_tick;
  logic       key_up;
  logic       key_down;
  logic       add_x;
  logic [1:0] add_y;
  logic       y_pos_mod;
  logic       y_neg_mod;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;
  modport master (
    output frame_tick, key_up, key_down,
    input  add_x, add_y, y_pos_mod, y_neg_mod, colour, plot, busy, done
  );
  modport slave (
    input  frame_tick, key_up, key_down,
    output add_x, add_y, y_pos_mod, y_neg_mod, colour, plot, busy, done
  );
endinterface

// File: rtl/player_draw_fsm.sv
// player_draw_fsm: per-frame erase/move/settle/draw sequencer for the player ship; PLAYER_DRAW_STILL_SKIP_EN skips the redraw when no move happens
module player_draw_fsm #(
  parameter logic [2:0] SHIP_COLOUR   = 3'b010,
  parameter logic [2:0] BG_COLOUR     = 3'b000,
  parameter int         Y_MAX         = 116,
  parameter int         SETTLE_CYCLES = 2
) (
  input logic              clk,
  input logic              reset_n,
  player_draw_fsm_if.slave bus
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ERASE  = 3'd1;
  localparam logic [2:0] MOVE   = 3'd2;
  localparam logic [2:0] SETTLE = 3'd3;
  localparam logic [2:0] DRAW   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;
  localparam logic [6:0] YM     = 7'(Y_MAX);
  localparam logic [2:0] SL     = 3'(SETTLE_CYCLES - 1);
  logic [2:0] state, cnt;
  logic [6:0] shadow_y;
  logic       pending, req_up, req_down;
  logic       start, can_up, can_down, skip;
  assign start    = bus.frame_tick | pending;
  assign can_up   = req_up & ~req_down & (shadow_y < YM);
  assign can_down = req_down & ~req_up & (shadow_y != 7'd0);
`ifdef PLAYER_DRAW_STILL_SKIP_EN
  assign skip = ~((bus.key_up & ~bus.key_down & (shadow_y < YM)) |
                  (bus.key_down & ~bus.key_up & (shadow_y != 7'd0)));
`else
  assign skip = 1'b0;
`endif
  // outputs decode straight from registered state/counter so async reset clears them at once
  assign bus.plot      = (state == ERASE) || (state == DRAW);
  assign bus.add_x     = bus.plot ? cnt[0] : 1'b0;
  assign bus.add_y     = bus.plot ? cnt[2:1] : 2'd0;
  assign bus.colour    = (state == DRAW) ? SHIP_COLOUR : BG_COLOUR;
  assign bus.busy      = state != IDLE;
  assign bus.done      = state == DONE;
  assign bus.y_pos_mod = (state == MOVE) & can_up;
  assign bus.y_neg_mod = (state == MOVE) & can_down;
  // ticks arriving outside IDLE collapse into a single pending start
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) pending <= 1'b0;
    else pending <= (state == IDLE) ? 1'b0 : (pending | bus.frame_tick);
  // sequence stepping, key latch and shadow of the ship y origin
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 3'd0;
      shadow_y <= 7'd0;
      req_up   <= 1'b0;
      req_down <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= skip ? DONE : ERASE;
          cnt      <= 3'd0;
          req_up   <= bus.key_up;
          req_down <= bus.key_down;
        end
        ERASE: begin
          cnt   <= cnt + 3'd1;
          state <= (cnt == 3'd7) ? MOVE : ERASE;
        end
        MOVE: begin
          state    <= SETTLE;
          cnt      <= 3'd0;
          shadow_y <= can_up ? shadow_y + 7'd1 : can_down ? shadow_y - 7'd1 : shadow_y;
        end
        SETTLE: begin
          cnt   <= (cnt == SL) ? 3'd0 : cnt + 3'd1;
          state <= (cnt == SL) ? DRAW : SETTLE;
        end
        DRAW: begin
          cnt   <= cnt + 3'd1;
          state <= (cnt == 3'd7) ? DONE : DRAW;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_player_draw_fsm.sv
// tb_player_draw_fsm: directed bench for the player draw sequencer, default build
module tb_player_draw_fsm;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   passed = 0;
  int   total = 0;
  int   sh1 = 0;
  int   sh2 = 0;
  always #5 clk = ~clk;
  player_draw_fsm_if b1();
  player_draw_fsm_if b2();
  player_draw_fsm dut (.clk(clk), .reset_n(reset_n), .bus(b1));
  player_draw_fsm #(.Y_MAX(2)) dut2 (.clk(clk), .reset_n(reset_n), .bus(b2));
  assign b2.frame_tick = b1.frame_tick;
  assign b2.key_up     = b1.key_up;
  assign b2.key_down   = b1.key_down;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  function automatic logic pp(input int r);
    return (r >= 1 && r <= 8) || (r >= 12 && r <= 19);
  endfunction

  function automatic logic bz(input int r);
    return r >= 1 && r <= 20;
  endfunction

  task automatic seq(input logic up, input logic dn, input logic flip, input string tag);
    logic e1, e2, en1, en2, ep;
    int bad, pos1, pos2, neg1, neg2, k;
    e1  = up && !dn && sh1 < 116;
    e2  = up && !dn && sh2 < 2;
    en1 = dn && !up && sh1 > 0;
    en2 = dn && !up && sh2 > 0;
    bad = 0; pos1 = 0; pos2 = 0; neg1 = 0; neg2 = 0;
    b1.frame_tick = 1'b1;
    b1.key_up     = up;
    b1.key_down   = dn;
    step;
    b1.frame_tick = 1'b0;
    for (int c = 1; c <= 22; c++) begin
      if (flip && c == 5) begin
        b1.key_up   = !up;
        b1.key_down = !dn;
      end
      ep = pp(c);
      k  = (c <= 8) ? c - 1 : c - 12;
      if (b1.plot !== ep || b1.busy !== bz(c) || b1.done !== (c == 20)) bad++;
      if (ep && (b1.add_x !== k[0] || b1.add_y !== k[2:1] ||
                 b1.colour !== ((c >= 12) ? 3'b010 : 3'b000))) bad++;
      if (b1.y_pos_mod) pos1 += c;
      if (b1.y_neg_mod) neg1 += c;
      if (b2.y_pos_mod) pos2 += c;
      if (b2.y_neg_mod) neg2 += c;
      step;
    end
    b1.key_up   = 1'b0;
    b1.key_down = 1'b0;
    chk({tag, "_trace"}, bad, 0);
    chk({tag, "_pos"}, pos1, e1 ? 9 : 0);
    chk({tag, "_neg"}, neg1, en1 ? 9 : 0);
    chk({tag, "_pos_ymax2"}, pos2, e2 ? 9 : 0);
    chk({tag, "_neg_ymax2"}, neg2, en2 ? 9 : 0);
    sh1 += e1 ? 1 : en1 ? -1 : 0;
    sh2 += e2 ? 1 : en2 ? -1 : 0;
    repeat (8) step;
  endtask

  initial begin
    int bad, dsum;
    b1.frame_tick = 1'b0;
    b1.key_up     = 1'b0;
    b1.key_down   = 1'b0;
    step;
    step;
    chk("rst_plot", int'(b1.plot), 0);
    chk("rst_busy", int'(b1.busy), 0);
    chk("rst_done", int'(b1.done), 0);
    chk("rst_colour", int'(b1.colour), 0);
    chk("rst_offsets", int'({b1.add_x, b1.add_y}), 0);
    chk("rst_mods", int'({b1.y_pos_mod, b1.y_neg_mod}), 0);
    reset_n = 1'b1;
    repeat (3) step;
    seq(1'b0, 1'b0, 1'b0, "still");
    seq(1'b0, 1'b1, 1'b0, "down_at_zero");
    seq(1'b1, 1'b0, 1'b0, "up1");
    seq(1'b1, 1'b0, 1'b1, "up2_keyflip");
    seq(1'b1, 1'b0, 1'b0, "up3");
    chk("shadow_after_ups", sh1, 3);
    seq(1'b1, 1'b1, 1'b0, "both_keys");
    seq(1'b0, 1'b1, 1'b1, "down");
    bad = 0;
    dsum = 0;
    b1.frame_tick = 1'b1;
    step;
    for (int c = 1; c <= 66; c++) begin
      b1.frame_tick = (c == 5 || c == 7 || c == 41);
      if (b1.busy !== (bz(c) || bz(c - 21) || bz(c - 42))) bad++;
      if (b1.plot !== (pp(c) || pp(c - 21) || pp(c - 42))) bad++;
      if (b1.y_pos_mod || b1.y_neg_mod) bad++;
      if (b1.done) dsum += c;
      step;
    end
    b1.frame_tick = 1'b0;
    chk("pending_trace", bad, 0);
    chk("pending_done_cycles", dsum, 20 + 41 + 62);
    repeat (4) step;
    b1.frame_tick = 1'b1;
    b1.key_up     = 1'b1;
    step;
    b1.frame_tick = 1'b0;
    repeat (3) step;
    chk("pre_reset_plot", int'(b1.plot), 1);
    chk("pre_reset_add_x", int'(b1.add_x), 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_plot", int'(b1.plot), 0);
    chk("async_rst_busy", int'(b1.busy), 0);
    chk("async_rst_add_x", int'(b1.add_x), 0);
    chk("async_rst_add_y", int'(b1.add_y), 0);
    step;
    step;
    chk("held_rst_mods", int'({b1.y_pos_mod, b1.y_neg_mod}), 0);
    reset_n     = 1'b1;
    b1.key_up   = 1'b0;
    sh1 = 0;
    sh2 = 0;
    step;
    seq(1'b0, 1'b1, 1'b0, "down_after_reset");
    seq(1'b1, 1'b0, 1'b0, "up_after_reset");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/player_draw_fsm.md
Name: player_draw_fsm

Overview:
- Per-frame sequencer that drives the player ship position block.
- On each 60 Hz frame tick it:
  - erases the ship at its old position;
  - issues at most one one-cycle vertical move pulse (up/down) from the buttons;
  - waits for the ship position register to settle;
  - redraws the ship.
- Outputs are the sprite pixel offsets and move pulses consumed by the player block, plus colour/plot for the VGA adapter.

Parameters:
- SHIP_COLOUR, 3'b010, colour used in the DRAW phase.
- BG_COLOUR, 3'b000, colour used in the ERASE phase.
- Y_MAX, 116, largest legal ship y origin; up-moves are suppressed at this value.
- SETTLE_CYCLES, 2, idle cycles after MOVE before DRAW (covers the two-stage position update); legal range 1..7.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- frame_tick  input  1  one-cycle pulse, start of frame.
- key_up  input  1  level, request y increment.
- key_down  input  1  level, request y decrement.
- add_x  output  1  sprite column offset to the player block.
- add_y  output  2  sprite row offset to the player block.
- y_pos_mod  output  1  one-cycle pulse, increment ship y.
- y_neg_mod  output  1  one-cycle pulse, decrement ship y.
- colour  output  3  pixel colour to VGA.
- plot  output  1  VGA write enable.
- busy  output  1  high from the cycle after the accepted tick through DONE.
- done  output  1  one-cycle pulse at end of sequence.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on reset_n.
- Reset values, applied immediately on reset_n low:
  - state = IDLE.
  - add_x = 0, add_y = 0, y_pos_mod = 0, y_neg_mod = 0, plot = 0, busy = 0, done = 0.
  - colour = BG_COLOUR.
  - shadow_y = 0, pending = 0.
- Reset mid-sequence aborts with no further plot/move pulses.
- States: IDLE, ERASE, MOVE, SETTLE, DRAW, DONE.
- IDLE:
  - If frame_tick or pending is set: go to ERASE next cycle, clear pending, and latch the move request from key_up/key_down this cycle.
- ERASE: 8 cycles with plot = 1 and colour = BG_COLOUR.
  - Scan in raster order, add_x fastest: (x,y) = (0,0),(1,0),(0,1),(1,1) … (1,3).
  - Offsets are registered and aligned with plot.
- MOVE: 1 cycle, plot = 0.
  - Latched up and shadow_y < Y_MAX: y_pos_mod = 1, shadow_y += 1.
  - Latched down and shadow_y > 0: y_neg_mod = 1, shadow_y -= 1.
  - Both or neither latched: no pulse. Key_up and key_down held together cancel.
- SETTLE: SETTLE_CYCLES cycles, plot = 0, no move pulses.
- DRAW: 8 cycles with plot = 1 and colour = SHIP_COLOUR, same scan order as ERASE.
- DONE: 1 cycle with done = 1, then return to IDLE.
- Latency with default SETTLE_CYCLES = 2, tick sampled at cycle 0:
  - ERASE plots cycles 1–8.
  - MOVE cycle 9.
  - SETTLE cycles 10–11.
  - DRAW plots cycles 12–19.
  - done cycle 20; back in IDLE at cycle 21.
  - busy is high cycles 1–20.
- frame_tick while busy: sets pending. Multiple ticks while busy collapse into one pending. A pending tick starts a new sequence on the cycle after DONE (IDLE lasts exactly 1 cycle). A tick arriving in the same cycle as DONE also sets pending.
- Keys are sampled only in the IDLE cycle that starts a sequence. Key changes mid-sequence have no effect.
- y_pos_mod and y_neg_mod are never both high. Neither is ever high outside MOVE.
- shadow_y is 7 bits, saturating in [0, Y_MAX]. It mirrors the player block's origin, which shares reset_n.

Optional Feature:
- Macro: PLAYER_DRAW_STILL_SKIP_EN.
- Defined: if the latched request produces no move pulse (no key, both keys, or saturated), go directly from IDLE to DONE. The sequence is IDLE → DONE → IDLE, with no plot cycles; busy is high for that 1 cycle.
- Undefined: the full ERASE/MOVE/SETTLE/DRAW sequence runs every tick, including redraw at the unchanged position.

Test Plan:
- Reset then tick with no keys (macro undefined) -> plot high cycles 1–8 (colour 000) and 12–19 (colour 010); offsets (0,0)…(1,3) in order each phase; no mod pulse; done at cycle 20.
- key_up held, 3 ticks spaced 30 cycles -> exactly one y_pos_mod pulse per sequence, each at cycle 9 relative to its tick; shadow_y = 3.
- From shadow_y = 0, tick with key_down -> no y_neg_mod; shadow_y stays 0. From shadow_y = Y_MAX (set Y_MAX=2, 2 up-ticks), a third up-tick -> no y_pos_mod.
- key_up and key_down both held, tick -> no mod pulse. With PLAYER_DRAW_STILL_SKIP_EN: done at cycle 1, plot never high.
- Tick at cycle 0, extra ticks at cycles 5 and 7 -> second sequence starts ERASE at cycle 22; no third sequence.
- reset_n low at cycle 4 (mid-ERASE) -> plot, busy, add_x, add_y low in same cycle; after release, a tick runs a full clean sequence with shadow_y = 0.
